// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FP operation sequencer.
// Holds the FSM state encoding, rounding modes, flag positions and the fcsr layout.
package fpu_seq_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned FRM_W     = 3;
   localparam int unsigned FLAG_W    = 5;
   localparam int unsigned FCSR_W    = FRM_W + FLAG_W;

   localparam logic [FRM_W-1:0] RNE = 3'd0;
   localparam logic [FRM_W-1:0] RTZ = 3'd1;
   localparam logic [FRM_W-1:0] RDN = 3'd2;
   localparam logic [FRM_W-1:0] RUP = 3'd3;
   localparam logic [FRM_W-1:0] RMM = 3'd4;
   localparam logic [FRM_W-1:0] DYN = 3'd7;

   localparam int unsigned NV = 4;
   localparam int unsigned DZ = 3;
   localparam int unsigned OF = 2;
   localparam int unsigned UF = 1;
   localparam int unsigned NX = 0;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_EXEC = 3'd2,
      S_WB   = 3'd3,
      S_DONE = 3'd4
   } seq_state_t;

   typedef struct packed {
      logic [FRM_W-1:0]  frm;
      logic [FLAG_W-1:0] fflags;
   } fcsr_t;

   // Only the five architected static modes may reach the FPU.
   function automatic logic rm_is_legal(input logic [FRM_W-1:0] rm);
      return (rm == RNE) || (rm == RTZ) || (rm == RDN) || (rm == RUP) || (rm == RMM);
   endfunction

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// Request, register-file, FPU and fcsr signals of the FP operation sequencer.
// master = surrounding pipeline/RF/FPU side, slave = the sequencer.
interface fpu_op_sequencer_if #(
   parameter int unsigned FUNCT7_W = 7
);
   import fpu_seq_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic [FUNCT7_W-1:0]  req_funct7;
   logic [REG_IDX_W-1:0] req_rs1;
   logic [REG_IDX_W-1:0] req_rs2;
   logic [REG_IDX_W-1:0] req_rd;
   logic [FRM_W-1:0]     req_rm;

   logic [REG_IDX_W-1:0] rf_rs1;
   logic [REG_IDX_W-1:0] rf_rs2;
   logic [XLEN-1:0]      rf_rs1_data;
   logic [XLEN-1:0]      rf_rs2_data;
   logic                 rf_wen;
   logic [REG_IDX_W-1:0] rf_rd;
   logic [XLEN-1:0]      rf_w_data;

   logic                 fpu_start;
   logic [FUNCT7_W-1:0]  fpu_funct7;
   logic [FRM_W-1:0]     fpu_frm;
   logic [XLEN-1:0]      fpu_op1;
   logic [XLEN-1:0]      fpu_op2;
   logic [XLEN-1:0]      fpu_out;
   logic [FLAG_W-1:0]    fpu_flags;
   logic                 fpu_ready;

   logic                 csr_wen;
   logic [FCSR_W-1:0]    csr_wdata;
   logic [FCSR_W-1:0]    fcsr_out;

   logic                 done;
   logic                 err_illegal;
   logic                 err_timeout;

   modport master (
      output req_valid, req_funct7, req_rs1, req_rs2, req_rd, req_rm,
      output rf_rs1_data, rf_rs2_data,
      output fpu_out, fpu_flags, fpu_ready,
      output csr_wen, csr_wdata,
      input  req_ready, rf_rs1, rf_rs2, rf_wen, rf_rd, rf_w_data,
      input  fpu_start, fpu_funct7, fpu_frm, fpu_op1, fpu_op2,
      input  fcsr_out, done, err_illegal, err_timeout
   );

   modport slave (
      input  req_valid, req_funct7, req_rs1, req_rs2, req_rd, req_rm,
      input  rf_rs1_data, rf_rs2_data,
      input  fpu_out, fpu_flags, fpu_ready,
      input  csr_wen, csr_wdata,
      output req_ready, rf_rs1, rf_rs2, rf_wen, rf_rd, rf_w_data,
      output fpu_start, fpu_funct7, fpu_frm, fpu_op1, fpu_op2,
      output fcsr_out, done, err_illegal, err_timeout
   );

endinterface

// File: rtl/fpu_fcsr_reg.sv
// fcsr storage: CSR writes, sticky exception accumulation and rounding-mode resolution.
// A CSR write and a flag accumulate in the same cycle merge as write-then-OR.
module fpu_fcsr_reg
   import fpu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              csr_wen,
   input  fcsr_t             csr_wdata,
   input  logic              acc_en,
   input  logic [FLAG_W-1:0] acc_flags,
   input  logic [FRM_W-1:0]  req_rm,
   output fcsr_t             fcsr,
   output logic [FRM_W-1:0]  rm_eff_c,
   output logic              rm_illegal_c
);

   fcsr_t fcsr_nxt;

   always_comb begin
      fcsr_nxt = fcsr;
      if (csr_wen) begin
         fcsr_nxt = csr_wdata;
      end
      if (acc_en) begin
         fcsr_nxt.fflags = fcsr_nxt.fflags | acc_flags;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         fcsr <= '0;
      end else begin
         fcsr <= fcsr_nxt;
      end
   end

   // Dynamic mode takes the frm currently held, before any same-cycle CSR write.
   always_comb begin
      rm_eff_c     = (req_rm == DYN) ? fcsr.frm : req_rm;
      rm_illegal_c = !rm_is_legal(rm_eff_c);
   end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Single-issue FP instruction sequencer: operand read, FPU execute with timeout, writeback.
// All bus outputs are registered and aligned with the state they describe.
module fpu_op_sequencer
   import fpu_seq_pkg::*;
#(
   parameter int unsigned FUNCT7_W = 7,
   parameter int unsigned TIMEOUT  = 64
) (
   input logic               clk,
   input logic               n_rst,
   fpu_op_sequencer_if.slave bus
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   seq_state_t state, state_nxt;
   logic       accept_c;
   logic       illegal_nxt;
   logic       timeout_nxt;

   logic [CNT_W-1:0]     cnt;
   logic [FUNCT7_W-1:0]  funct7_q;
   logic [REG_IDX_W-1:0] rs1_q;
   logic [REG_IDX_W-1:0] rs2_q;
   logic [REG_IDX_W-1:0] rd_q;
   logic [FRM_W-1:0]     frm_q;
   logic [XLEN-1:0]      op1_q;
   logic [XLEN-1:0]      op2_q;
   logic [XLEN-1:0]      res_q;
   logic [FLAG_W-1:0]    flags_q;

   logic req_ready_q;
   logic fpu_start_q;
   logic rf_wen_q;
   logic done_q;
   logic err_illegal_q;
   logic err_timeout_q;

   fcsr_t            fcsr;
   logic [FRM_W-1:0] rm_eff_c;
   logic             rm_illegal_c;

   fpu_fcsr_reg u_fcsr (
      .clk          (clk),
      .n_rst        (n_rst),
      .csr_wen      (bus.csr_wen),
      .csr_wdata    (fcsr_t'(bus.csr_wdata)),
      .acc_en       (state == S_WB),
      .acc_flags    (flags_q),
      .req_rm       (bus.req_rm),
      .fcsr         (fcsr),
      .rm_eff_c     (rm_eff_c),
      .rm_illegal_c (rm_illegal_c)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      accept_c    = 1'b0;
      illegal_nxt = 1'b0;
      timeout_nxt = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.req_valid) begin
               accept_c = 1'b1;
               if (rm_illegal_c) begin
                  state_nxt   = S_DONE;
                  illegal_nxt = 1'b1;
               end else begin
                  state_nxt = S_READ;
               end
            end
         end
         S_READ: state_nxt = S_EXEC;
         S_EXEC: begin
            // A result arriving on the last allowed cycle still wins over the abort.
            if (bus.fpu_ready) begin
               state_nxt = S_WB;
            end else if (cnt == CNT_LAST) begin
               state_nxt   = S_DONE;
               timeout_nxt = 1'b1;
            end
         end
         S_WB:    state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         req_ready_q   <= 1'b1;
         fpu_start_q   <= 1'b0;
         rf_wen_q      <= 1'b0;
         done_q        <= 1'b0;
         err_illegal_q <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         req_ready_q   <= (state_nxt == S_IDLE);
         fpu_start_q   <= (state_nxt == S_EXEC) && (state != S_EXEC);
         rf_wen_q      <= (state_nxt == S_WB);
         done_q        <= (state_nxt == S_DONE);
         err_illegal_q <= illegal_nxt;
         err_timeout_q <= timeout_nxt;
      end
   end

   // Request fields, operands and result are held until the next transaction overwrites them.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         funct7_q <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         frm_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         res_q    <= '0;
         flags_q  <= '0;
      end else begin
         if (accept_c) begin
            funct7_q <= bus.req_funct7;
            rs1_q    <= bus.req_rs1;
            rs2_q    <= bus.req_rs2;
            rd_q     <= bus.req_rd;
            frm_q    <= rm_eff_c;
         end
         if (state == S_READ) begin
            op1_q <= bus.rf_rs1_data;
            op2_q <= bus.rf_rs2_data;
         end
         if ((state == S_EXEC) && bus.fpu_ready) begin
            res_q   <= bus.fpu_out;
            flags_q <= bus.fpu_flags;
         end
      end
   end

   // Cycle counter is zero on the first EXEC cycle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt <= '0;
      end else if (state == S_EXEC) begin
         cnt <= cnt + CNT_W'(1);
      end else begin
         cnt <= '0;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rf_rs1      = rs1_q;
   assign bus.rf_rs2      = rs2_q;
   assign bus.rf_wen      = rf_wen_q;
   assign bus.rf_rd       = rd_q;
   assign bus.rf_w_data   = res_q;
   assign bus.fpu_start   = fpu_start_q;
   assign bus.fpu_funct7  = funct7_q;
   assign bus.fpu_frm     = frm_q;
   assign bus.fpu_op1     = op1_q;
   assign bus.fpu_op2     = op2_q;
   assign bus.fcsr_out    = fcsr;
   assign bus.done        = done_q;
   assign bus.err_illegal = err_illegal_q;
   assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with a register-file array and a fixed-latency FPU model.
module tb_fpu_op_sequencer;

   logic clk;
   logic n_rst;

   fpu_op_sequencer_if #(.FUNCT7_W(7)) bus ();

   fpu_op_sequencer #(.FUNCT7_W(7), .TIMEOUT(8)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] rf [32];
   assign bus.rf_rs1_data = rf[bus.rf_rs1];
   assign bus.rf_rs2_data = rf[bus.rf_rs2];

   // FPU model: result appears fpu_lat cycles after fpu_start (0 = same cycle).
   int          fpu_lat;
   int          fpu_cnt;
   logic        fpu_busy;
   logic [31:0] fpu_res;
   logic [4:0]  fpu_flg;

   assign bus.fpu_out   = fpu_res;
   assign bus.fpu_flags = fpu_flg;
   assign bus.fpu_ready = (bus.fpu_start && (fpu_lat == 0)) || (fpu_busy && (fpu_cnt == fpu_lat));

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         fpu_busy <= 1'b0;
         fpu_cnt  <= 0;
      end else if (bus.fpu_start && (fpu_lat != 0)) begin
         fpu_busy <= 1'b1;
         fpu_cnt  <= 1;
      end else if (fpu_busy) begin
         if (bus.fpu_ready) fpu_busy <= 1'b0;
         else               fpu_cnt  <= fpu_cnt + 1;
      end
   end

   int n_cmp;
   int n_fail;

   int          r_lat;
   int          r_start_cyc;
   int          r_starts;
   int          r_wens;
   logic [31:0] r_wdata;
   logic [4:0]  r_wrd;
   logic [2:0]  r_frm;
   logic        r_ill;
   logic        r_tmo;
   bit          r_rdy_low;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic csr_write(input logic [7:0] v);
      bus.csr_wdata = v;
      bus.csr_wen   = 1'b1;
      step();
      bus.csr_wen   = 1'b0;
   endtask

   // Issue one request and observe it up to done; cycle c counts edges after acceptance.
   task automatic run_op(input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [2:0] rm, input bit hold,
                         input bit csr_wb, input logic [7:0] csr_val);
      int guard;
      bus.req_funct7 = f7;
      bus.req_rs1    = rs1;
      bus.req_rs2    = rs2;
      bus.req_rd     = rd;
      bus.req_rm     = rm;
      bus.req_valid  = 1'b1;
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
         step();
         guard++;
      end
      step();
      if (!hold) bus.req_valid = 1'b0;
      r_lat = -1; r_start_cyc = -1; r_starts = 0; r_wens = 0;
      r_wdata = '0; r_wrd = '0; r_frm = '0; r_ill = 1'b0; r_tmo = 1'b0; r_rdy_low = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         if (bus.req_ready) r_rdy_low = 1'b0;
         if (bus.fpu_start) begin
            r_starts++;
            r_start_cyc = c;
            r_frm = bus.fpu_frm;
         end
         if (bus.rf_wen) begin
            r_wens++;
            r_wdata = bus.rf_w_data;
            r_wrd   = bus.rf_rd;
            if (csr_wb) begin
               bus.csr_wdata = csr_val;
               bus.csr_wen   = 1'b1;
            end
         end
         if (bus.done) begin
            r_lat = c;
            r_ill = bus.err_illegal;
            r_tmo = bus.err_timeout;
            break;
         end
         step();
         bus.csr_wen = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int late_evt;
      n_cmp = 0; n_fail = 0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
      rf[1] = 32'h3F80_0000;
      rf[2] = 32'h4000_0000;
      fpu_lat = 0; fpu_res = '0; fpu_flg = '0;
      bus.req_valid = 1'b0; bus.req_funct7 = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
      bus.req_rd = '0; bus.req_rm = '0; bus.csr_wen = 1'b0; bus.csr_wdata = '0;
      n_rst = 1'b0;
      step(); step();
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_done",      32'(bus.done),      32'd0);
      check("rst_rf_wen",    32'(bus.rf_wen),    32'd0);
      check("rst_fpu_start", 32'(bus.fpu_start), 32'd0);
      check("rst_fcsr",      32'(bus.fcsr_out),  32'h00);
      #3 n_rst = 1'b1;
      step();

      // Basic add, FPU answers 3 cycles after launch
      fpu_lat = 3; fpu_res = 32'h4040_0000; fpu_flg = 5'b00000;
      run_op(7'd0, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 1'b0, 8'h00);
      check("add_latency", 32'(r_lat),    32'd7);
      check("add_starts",  32'(r_starts), 32'd1);
      check("add_frm",     32'(r_frm),    32'd0);
      check("add_wens",    32'(r_wens),   32'd1);
      check("add_wdata",   r_wdata,       32'h4040_0000);
      check("add_rd",      32'(r_wrd),    32'd3);
      check("add_op1",     bus.fpu_op1,   32'h3F80_0000);
      check("add_op2",     bus.fpu_op2,   32'h4000_0000);
      check("add_fcsr",    32'(bus.fcsr_out), 32'h00);

      // Dynamic rounding resolves to frm=RUP
      csr_write(8'h60);
      check("csr_write_60", 32'(bus.fcsr_out), 32'h60);
      fpu_lat = 1; fpu_res = 32'h1234_5678;
      run_op(7'd1, 5'd1, 5'd2, 5'd4, 3'b111, 1'b0, 1'b0, 8'h00);
      check("dyn_latency", 32'(r_lat),  32'd5);
      check("dyn_frm",     32'(r_frm),  32'd3);
      check("dyn_wdata",   r_wdata,     32'h1234_5678);

      // Dynamic with frm=7 is illegal
      csr_write(8'hE0);
      run_op(7'd1, 5'd1, 5'd2, 5'd4, 3'b111, 1'b0, 1'b0, 8'h00);
      check("ill_latency", 32'(r_lat),    32'd1);
      check("ill_flag",    32'(r_ill),    32'd1);
      check("ill_starts",  32'(r_starts), 32'd0);
      check("ill_wens",    32'(r_wens),   32'd0);
      check("ill_fcsr",    32'(bus.fcsr_out), 32'hE0);

      // Static reserved mode 101 is illegal too
      csr_write(8'h00);
      run_op(7'd2, 5'd1, 5'd2, 5'd4, 3'b101, 1'b0, 1'b0, 8'h00);
      check("ill101_flag", 32'(r_ill),  32'd1);
      check("ill101_wens", 32'(r_wens), 32'd0);

      // Sticky flag accumulation
      fpu_lat = 0; fpu_res = 32'h0000_0011; fpu_flg = 5'b00001;
      run_op(7'd3, 5'd1, 5'd2, 5'd7, 3'b000, 1'b0, 1'b0, 8'h00);
      check("sticky1_latency", 32'(r_lat),          32'd4);
      check("sticky1_fcsr",    32'(bus.fcsr_out),   32'h01);
      fpu_lat = 2; fpu_res = 32'h0000_0022; fpu_flg = 5'b10000;
      run_op(7'd3, 5'd1, 5'd2, 5'd8, 3'b001, 1'b0, 1'b0, 8'h00);
      check("sticky2_latency", 32'(r_lat),          32'd6);
      check("sticky2_fcsr",    32'(bus.fcsr_out),   32'h11);
      // CSR clear during WB merges with this op's flags; rd=0 is a real register
      fpu_lat = 1; fpu_res = 32'h0000_0033; fpu_flg = 5'b00100;
      run_op(7'd3, 5'd1, 5'd2, 5'd0, 3'b000, 1'b0, 1'b1, 8'h00);
      check("sticky3_fcsr",  32'(bus.fcsr_out), 32'h04);
      check("rd0_wens",      32'(r_wens),       32'd1);
      check("rd0_rd",        32'(r_wrd),        32'd0);
      check("rd0_wdata",     r_wdata,           32'h0000_0033);

      // Hung FPU hits the timeout
      fpu_lat = 255; fpu_flg = 5'b11111;
      run_op(7'd4, 5'd1, 5'd2, 5'd9, 3'b000, 1'b0, 1'b0, 8'h00);
      check("tmo_latency",   32'(r_lat),              32'd10);
      check("tmo_exec_span", 32'(r_lat - r_start_cyc), 32'd8);
      check("tmo_flag",      32'(r_tmo),              32'd1);
      check("tmo_wens",      32'(r_wens),             32'd0);
      check("tmo_fcsr",      32'(bus.fcsr_out),       32'h04);
      fpu_lat = 0; fpu_res = 32'h0000_0044; fpu_flg = 5'b00000;
      run_op(7'd4, 5'd1, 5'd2, 5'd9, 3'b000, 1'b0, 1'b0, 8'h00);
      check("post_tmo_latency", 32'(r_lat),   32'd4);
      check("post_tmo_wdata",   r_wdata,      32'h0000_0044);

      // Back-to-back with zero-latency FPU and req_valid held
      fpu_lat = 0; fpu_res = 32'hAAAA_0001;
      run_op(7'd5, 5'd1, 5'd2, 5'd5, 3'b010, 1'b1, 1'b0, 8'h00);
      check("b2b_a_latency", 32'(r_lat),     32'd4);
      check("b2b_a_rdy_low", 32'(r_rdy_low), 32'd1);
      check("b2b_a_rd",      32'(r_wrd),     32'd5);
      check("b2b_a_wdata",   r_wdata,        32'hAAAA_0001);
      fpu_res = 32'hBBBB_0002;
      run_op(7'd6, 5'd2, 5'd1, 5'd6, 3'b100, 1'b0, 1'b0, 8'h00);
      check("b2b_b_latency", 32'(r_lat),     32'd4);
      check("b2b_b_rdy_low", 32'(r_rdy_low), 32'd1);
      check("b2b_b_rd",      32'(r_wrd),     32'd6);
      check("b2b_b_wdata",   r_wdata,        32'hBBBB_0002);
      check("b2b_b_frm",     32'(r_frm),     32'd4);
      step();
      check("b2b_idle_ready", 32'(bus.req_ready), 32'd1);

      // Reset while waiting on the FPU
      fpu_lat = 255;
      bus.req_funct7 = 7'd7; bus.req_rs1 = 5'd1; bus.req_rs2 = 5'd2;
      bus.req_rd = 5'd10; bus.req_rm = 3'b000; bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      step(); step(); step();
      #2 n_rst = 1'b0;
      #1;
      check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("mid_rst_fpu_start", 32'(bus.fpu_start), 32'd0);
      check("mid_rst_rf_wen",    32'(bus.rf_wen),    32'd0);
      check("mid_rst_done",      32'(bus.done),      32'd0);
      check("mid_rst_fcsr",      32'(bus.fcsr_out),  32'h00);
      check("mid_rst_op1",       bus.fpu_op1,        32'h0);
      step();
      #3 n_rst = 1'b1;
      late_evt = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.rf_wen || bus.done) late_evt++;
      end
      check("mid_rst_no_late_evt", 32'(late_evt),       32'd0);
      check("mid_rst_ready_after", 32'(bus.req_ready),  32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Single-issue controller that sequences one FP instruction at a time through operand read, FPU execute and register-file writeback.
- Sits between decode/control and the FP register file and FPU.
- Resolves dynamic rounding mode, owns the fcsr frm/fflags state, accumulates sticky exception flags and times out a hung FPU.

Parameters:
- FUNCT7_W, 7, width of the FPU operation select.
- TIMEOUT, 64, max cycles spent in EXEC waiting for fpu_ready before abort (>=2).

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- req_valid  in  1  instruction request.
- req_ready  out  1  sequencer can accept a request (high only in IDLE).
- req_funct7  in  FUNCT7_W  FPU operation.
- req_rs1  in  5  source register index.
- req_rs2  in  5  source register index.
- req_rd  in  5  destination register index.
- req_rm  in  3  instruction rounding mode (3'b111 = dynamic).
- rf_rs1  out  5  register-file read index.
- rf_rs2  out  5  register-file read index.
- rf_rs1_data  in  32  combinational read data.
- rf_rs2_data  in  32  combinational read data.
- rf_wen  out  1  writeback strobe.
- rf_rd  out  5  writeback index.
- rf_w_data  out  32  writeback data.
- fpu_start  out  1  one-cycle launch pulse.
- fpu_funct7  out  FUNCT7_W  latched operation.
- fpu_frm  out  3  resolved rounding mode.
- fpu_op1  out  32  latched operand.
- fpu_op2  out  32  latched operand.
- fpu_out  in  32  FPU result.
- fpu_flags  in  5  {NV,DZ,OF,UF,NX}, valid with fpu_ready.
- fpu_ready  in  1  FPU result valid.
- csr_wen  in  1  fcsr write.
- csr_wdata  in  8  {frm[2:0], fflags[4:0]}.
- fcsr_out  out  8  current {frm, fflags}.
- done  out  1  one-cycle completion pulse.
- err_illegal  out  1  qualifier valid with done.
- err_timeout  out  1  qualifier valid with done.

Behaviour:
- Reset (async, n_rst low): state=IDLE, frm=0, fflags=0. All outputs 0 except req_ready=1.
- States: IDLE, READ, EXEC, WB, DONE.
- IDLE:
  - req_ready=1. On req_valid, latch funct7/rs1/rs2/rd/rm; go to READ.
  - Resolve rounding mode: rm_eff = (rm==3'b111) ? frm : rm.
  - If rm_eff is 3'b101, 3'b110 or 3'b111, the request is illegal: go to DONE with err_illegal=1, no register-file write, flags unchanged.
- READ: drive rf_rs1/rf_rs2 from the latched indices; capture rf_rs1_data/rf_rs2_data into fpu_op1/op2; go to EXEC.
- EXEC:
  - fpu_start=1 on the first EXEC cycle only. fpu_funct7/fpu_frm/op1/op2 stay stable throughout EXEC.
  - Cycle counter is cleared on entry. On fpu_ready, capture fpu_out and fpu_flags; go to WB.
  - fpu_ready in the same cycle as fpu_start is legal (latency-0 FPU).
  - If the counter reaches TIMEOUT-1 without fpu_ready, go to DONE with err_timeout=1: no write, flags unchanged.
- WB:
  - rf_wen=1 for one cycle with rf_rd=latched rd, rf_w_data=captured result.
  - fflags <= fflags | captured flags (sticky OR). Go to DONE.
- DONE: done=1 for one cycle, errors valid this cycle only; return to IDLE. Minimum legal latency from request acceptance to done is 4 cycles.
- fcsr writes:
  - csr_wen loads frm/fflags in any state.
  - If csr_wen and a WB flag accumulate happen in the same cycle, the result is csr_wdata[4:0] | captured flags (write first, then OR).
  - A csr frm change during a live operation does not affect the already-resolved fpu_frm.
- rd = 0 is written normally; the FP register file has no hardwired zero.
- Reset mid-operation aborts immediately: no rf_wen and no done afterwards.
- fpu_ready outside EXEC is ignored.

Decomposition:
- Shared package fpu_seq_pkg holds:
  - state enum seq_state_t;
  - rounding-mode localparams RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4, DYN=7;
  - flag bit positions NV=4, DZ=3, OF=2, UF=1, NX=0;
  - the fcsr_t packed struct {frm, fflags}.
- One natural sub-module: fpu_fcsr_reg (frm/fflags storage, CSR write, sticky-OR merge, rounding-mode resolution and legality check).

Test Plan:
- Basic add: frm=0, req rm=000 funct7=0, rs1 holds 0x3F800000, rs2 holds 0x40000000, FPU returns 0x40400000 with flags=0 after 3 cycles → fpu_start once, fpu_frm=000, rf_wen with rd data 0x40400000, done 7 cycles after accept, fcsr_out=0x00.
- Dynamic rounding: csr write 0x60 (frm=3), req rm=111 → fpu_frm=011. Then csr write 0xE0, req rm=111 → err_illegal=1 with done, no rf_wen, no fpu_start.
- Sticky flags: op1 returns flags 5'b00001, op2 returns 5'b10000 → fcsr_out[4:0]=5'b10001. A csr write of 0x00 during op3's WB, with op3 returning 5'b00100, → fflags=5'b00100.
- Timeout: TIMEOUT=8, fpu_ready never asserted → done with err_timeout exactly 8 EXEC cycles after fpu_start, no rf_wen, fflags unchanged, next request accepted.
- Back-to-back and zero-latency: req_valid held high for two ops, FPU asserts fpu_ready together with fpu_start → req_ready low from acceptance until return to IDLE, both ops write back in order, 4-cycle latency each.
- Reset mid-EXEC: drop n_rst while waiting on the FPU → outputs return to reset values immediately, fcsr_out=0, no late rf_wen or done after release.
